rgb565_sobel_filter: RTL

Streaming pixel filter between the OV5640 capture stage (RGB565 stream in `cmos_pclk` domain) and the video frame buffer write port. Per frame it passes pixels through, converts them to grayscale, or produces a 3x3 Sobel edge-magnitude image. It keeps the input's sync and data-enable structure with a fixed latency, so the frame buffer sees the same pixel count per line.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/sobel_line_ram.sv | 22 ++
 rtl/rgb565_sobel_filter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types, constants and pixel helpers for the RGB565 gray/Sobel filter.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_SOBEL = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int LAT    = 4;
  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;

  // Worst-case weighted sum is 64088, so 16 bits hold it without wrap.
  function automatic logic [7:0] luma(input logic [15:0] px);
    logic [15:0] s;
    s = 16'(COEF_R) * 16'({px[15:11], 3'b0})
      + 16'(COEF_G) * 16'({px[10:5],  2'b0})
      + 16'(COEF_B) * 16'({px[4:0],   3'b0});
    return 8'(s >> 8);
  endfunction

  function automatic logic [15:0] pack565(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// One line of 8-bit luma: simple dual-port, synchronous read, no reset so it maps to block RAM.
module sobel_line_ram #(
  parameter int DEPTH = 1280,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
    if (we_i)    mem[wr_addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/rgb565_sobel_filter.sv
// Per-frame passthrough / grayscale / 3x3 Sobel magnitude on an RGB565 stream, fixed 4-cycle latency.
module rgb565_sobel_filter
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH = 1280,
  parameter int XW        = 11
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [1:0]  I_mode,
  input  logic        I_vs,
  input  logic        I_de,
  input  logic [15:0] I_data,
  output logic        O_vs,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic        O_line_ovf
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [XW-1:0] XMAX = XW'(MAX_WIDTH);
  localparam logic [XW-1:0] TWO  = XW'(2);

  logic [LAT:1]         vs_pipe_q, de_pipe_q;
  logic [LAT-1:1][15:0] data_pipe_q;
  logic [XW-1:0]        x_q, y_q, x1_q, y1_q;
  mode_e                mode_q, mode1_q, mode2_q, mode3_q;
  logic                 ovf_q, we1_q;
  logic [7:0]           luma1_q, luma2_q, luma3_q;
  logic [7:0]           rd0, rd1;
  logic [2:0][2:0][7:0] win_q;
  logic                 sob_zero2_q, oor2_q, sob_zero3_q, oor3_q;
  logic signed [10:0]   gx3_q, gy3_q;
  logic [15:0]          data4_q;

  logic          fs, in_rng, we0, line_start;
  logic [AW-1:0] rd_addr;
  logic [7:0]    luma0;
  logic [XW-1:0] y_cur;
  mode_e         mode_cur;

  // Frame start is seen against the registered vs; it applies to the pixel arriving with it.
  always_comb begin
    fs         = I_vs & ~vs_pipe_q[1];
    in_rng     = x_q < XMAX;
    we0        = I_de & in_rng;
    rd_addr    = in_rng ? x_q[AW-1:0] : '0;
    luma0      = luma(I_data);
    y_cur      = fs ? '0 : y_q;
    mode_cur   = fs ? mode_e'(I_mode) : mode_q;
    line_start = (x1_q == '0);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= MODE_PASS;
      ovf_q  <= 1'b0;
    end else begin
      if (I_de)              x_q <= (x_q == '1) ? x_q : x_q + 1'b1;
      else if (de_pipe_q[1]) x_q <= '0;
      if (fs)                                       y_q <= '0;
      else if (de_pipe_q[1] && !I_de && y_q != '1)  y_q <= y_q + 1'b1;
      if (fs) mode_q <= mode_e'(I_mode);
      if (I_de && !in_rng) ovf_q <= 1'b1;
      else if (fs)         ovf_q <= 1'b0;
    end
  end

  // Row y-1 lives in ram0; ram1 takes ram0's old word one cycle later to become row y-2.
  sobel_line_ram #(.DEPTH(MAX_WIDTH), .AW(AW)) u_ram0 (
    .clk_i(I_clk), .rd_en_i(I_de), .rd_addr_i(rd_addr), .rd_data_o(rd0),
    .we_i(we0), .wr_addr_i(rd_addr), .wr_data_i(luma0)
  );

  sobel_line_ram #(.DEPTH(MAX_WIDTH), .AW(AW)) u_ram1 (
    .clk_i(I_clk), .rd_en_i(I_de), .rd_addr_i(rd_addr), .rd_data_o(rd1),
    .we_i(we1_q), .wr_addr_i(x1_q[AW-1:0]), .wr_data_i(rd0)
  );

  logic [10:0] gxp, gxn, gyp, gyn;
  logic [10:0] ax, ay;
  logic [11:0] mag;
  logic [7:0]  sob;
  logic [15:0] out_d;

  always_comb begin
    gxp = 11'(win_q[0][2]) + {2'b0, win_q[1][2], 1'b0} + 11'(win_q[2][2]);
    gxn = 11'(win_q[0][0]) + {2'b0, win_q[1][0], 1'b0} + 11'(win_q[2][0]);
    gyp = 11'(win_q[2][0]) + {2'b0, win_q[2][1], 1'b0} + 11'(win_q[2][2]);
    gyn = 11'(win_q[0][0]) + {2'b0, win_q[0][1], 1'b0} + 11'(win_q[0][2]);
    ax  = gx3_q[10] ? $unsigned(-gx3_q) : $unsigned(gx3_q);
    ay  = gy3_q[10] ? $unsigned(-gy3_q) : $unsigned(gy3_q);
    mag = {1'b0, ax} + {1'b0, ay};
    sob = (mag > 12'd255) ? 8'hFF : mag[7:0];
    case (mode3_q)
      MODE_GRAY:  out_d = oor3_q      ? 16'h0000 : pack565(luma3_q);
      MODE_SOBEL: out_d = sob_zero3_q ? 16'h0000 : pack565(sob);
      default:    out_d = data_pipe_q[LAT-1];
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_pipe_q   <= '0;
      de_pipe_q   <= '0;
      data_pipe_q <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      mode1_q     <= MODE_PASS;
      mode2_q     <= MODE_PASS;
      mode3_q     <= MODE_PASS;
      we1_q       <= 1'b0;
      luma1_q     <= '0;
      luma2_q     <= '0;
      luma3_q     <= '0;
      win_q       <= '0;
      sob_zero2_q <= 1'b0;
      oor2_q      <= 1'b0;
      sob_zero3_q <= 1'b0;
      oor3_q      <= 1'b0;
      gx3_q       <= '0;
      gy3_q       <= '0;
      data4_q     <= '0;
    end else begin
      vs_pipe_q   <= {vs_pipe_q[LAT-1:1], I_vs};
      de_pipe_q   <= {de_pipe_q[LAT-1:1], I_de};
      data_pipe_q <= {data_pipe_q[LAT-2:1], I_data};
      // S1
      x1_q    <= x_q;
      y1_q    <= y_cur;
      mode1_q <= mode_cur;
      we1_q   <= we0;
      luma1_q <= luma0;
      // S2: the window restarts empty on the first pixel of every line
      if (de_pipe_q[1]) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= line_start ? 8'h00 : win_q[r][1];
          win_q[r][1] <= line_start ? 8'h00 : win_q[r][2];
        end
        win_q[0][2] <= rd1;
        win_q[1][2] <= rd0;
        win_q[2][2] <= luma1_q;
      end
      mode2_q     <= mode1_q;
      luma2_q     <= luma1_q;
      oor2_q      <= x1_q >= XMAX;
      sob_zero2_q <= (x1_q < TWO) || (y1_q < TWO) || (x1_q >= XMAX);
      // S3
      gx3_q       <= $signed(gxp - gxn);
      gy3_q       <= $signed(gyp - gyn);
      mode3_q     <= mode2_q;
      luma3_q     <= luma2_q;
      oor3_q      <= oor2_q;
      sob_zero3_q <= sob_zero2_q;
      // S4
      data4_q     <= out_d;
    end
  end

  assign O_vs       = vs_pipe_q[LAT];
  assign O_de       = de_pipe_q[LAT];
  assign O_data     = data4_q;
  assign O_line_ovf = ovf_q;

endmodule
